// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pipe_ctrl_pkg: shared types/constants for the pipeline hazard control |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package pipe_ctrl_pkg;

  localparam int REG_IDX_W              = 5;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | load_use_detect: flags an ID source that depends on a load in EXE     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0]           MemRead_EXE,
  input  logic [REG_IDX_W-1:0] rd_EXE,
  input  logic [REG_IDX_W-1:0] rs1_ID,
  input  logic [REG_IDX_W-1:0] rs2_ID,
  input  logic                 use_rs1_ID,
  input  logic                 use_rs2_ID,
  output logic                 load_use
);

  logic hit_rs1;
  logic hit_rs2;

  assign hit_rs1  = use_rs1_ID && (rs1_ID == rd_EXE);
  assign hit_rs2  = use_rs2_ID && (rs2_ID == rd_EXE);
  // x0 is hardwired zero, so a load into it never creates a dependency
  assign load_use = (|MemRead_EXE) && (rd_EXE != '0) && (hit_rs1 || hit_rs2);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline  |
// | Option: MEM_TIMEOUT_EN adds the wait counter, ERR state and mem_err.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3:0]           MemRead_EXE,
  input  logic [REG_IDX_W-1:0] rd_EXE,
  input  logic [REG_IDX_W-1:0] rs1_ID,
  input  logic [REG_IDX_W-1:0] rs2_ID,
  input  logic                 use_rs1_ID,
  input  logic                 use_rs2_ID,
  input  logic                 branch_taken_EXE,
  input  logic [3:0]           MemRead_MEM,
  input  logic [3:0]           MemWrite_MEM,
  input  logic                 dmem_ack,
  output logic                 dmem_req,
  output logic                 PC_Write,
  output logic                 IF_ID_REG_Write,
  output logic                 ID_EXE_REG_Write,
  output logic                 EXE_MEM_REG_Write,
  output logic                 MEM_WB_REG_Write,
  output logic                 IF_ID_flush,
  output logic                 ID_EXE_flush,
  output logic                 EXE_MEM_flush,
  output logic                 MEM_WB_flush,
  output logic                 mem_err
);

  if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_cnt_w_check
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

  state_e     state_q;
  state_e     state_d;
  logic       load_use;
  logic       mem_acc;
  logic       mem_stall;
  logic       timeout;
  logic [4:0] we;
  logic [3:0] fl;

  load_use_detect u_load_use_detect (
    .MemRead_EXE (MemRead_EXE),
    .rd_EXE      (rd_EXE),
    .rs1_ID      (rs1_ID),
    .rs2_ID      (rs2_ID),
    .use_rs1_ID  (use_rs1_ID),
    .use_rs2_ID  (use_rs2_ID),
    .load_use    (load_use)
  );

  assign mem_acc   = (|MemRead_MEM) || (|MemWrite_MEM);
  assign dmem_req  = reset_n && mem_acc && ((state_q == ST_RUN) || (state_q == ST_WAIT));
  assign mem_stall = dmem_req && !dmem_ack;

`ifdef MEM_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter holds zero outside WAIT, so entry into WAIT always starts from 0
  always_comb begin
    cnt_d = '0;
    if (state_q == ST_WAIT) begin
      cnt_d = cnt_q;
      if (mem_stall && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = (state_q == ST_WAIT) && mem_stall && (cnt_q >= CNT_LAST);
  assign mem_err = reset_n && (state_q == ST_ERR);
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (mem_stall) state_d = ST_WAIT;
      ST_WAIT: begin
        if (dmem_req && dmem_ack) begin
          state_d = ST_RUN;
        end else if (timeout) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Priority: reset/ERR freeze, memory stall, branch redirect, load-use bubble
  always_comb begin
    we = 5'b11111;
    fl = 4'b0000;
    if (!reset_n || (state_q == ST_ERR)) begin
      we = 5'b00000;
      fl = 4'b1111;
    end else if (mem_stall) begin
      we = 5'b00000;
      fl = 4'b0001;
    end else if (branch_taken_EXE) begin
      fl = 4'b1100;
    end else if (load_use) begin
      we = 5'b00111;
      fl = 4'b0100;
    end
  end

  assign {PC_Write, IF_ID_REG_Write, ID_EXE_REG_Write, EXE_MEM_REG_Write, MEM_WB_REG_Write} = we;
  assign {IF_ID_flush, ID_EXE_flush, EXE_MEM_flush, MEM_WB_flush} = fl;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_pipeline_hazard_ctrl: directed + random bench with reference model |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_pipeline_hazard_ctrl;

  localparam int TB_TIMEOUT = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  // Packed as {req, err, PC, IF_ID, ID_EXE, EXE_MEM, MEM_WB, fIF_ID, fID_EXE, fEXE_MEM, fMEM_WB}
  localparam logic [10:0] V_RST    = 11'b0_0_00000_1111;
  localparam logic [10:0] V_ERR    = 11'b0_1_00000_1111;
  localparam logic [10:0] V_IDLE   = 11'b0_0_11111_0000;
  localparam logic [10:0] V_LU     = 11'b0_0_00111_0100;
  localparam logic [10:0] V_BR     = 11'b0_0_11111_1100;
  localparam logic [10:0] V_STALL  = 11'b1_0_00000_0001;
  localparam logic [10:0] V_ACK    = 11'b1_0_11111_0000;
  localparam logic [10:0] V_ACK_BR = 11'b1_0_11111_1100;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] MemRead_EXE;
  logic [4:0] rd_EXE, rs1_ID, rs2_ID;
  logic       use_rs1_ID, use_rs2_ID, branch_taken_EXE;
  logic [3:0] MemRead_MEM, MemWrite_MEM;
  logic       dmem_ack;
  logic       dmem_req, PC_Write, IF_ID_REG_Write, ID_EXE_REG_Write, EXE_MEM_REG_Write;
  logic       MEM_WB_REG_Write, IF_ID_flush, ID_EXE_flush, EXE_MEM_flush, MEM_WB_flush, mem_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: "an access is outstanding", "WAIT cycles so far", "error latched"
  bit m_err      = 1'b0;
  bit m_waiting  = 1'b0;
  int m_wait_n   = 0;

  pipeline_hazard_ctrl #(
    .TIMEOUT_CYCLES (TB_TIMEOUT),
    .CNT_W          (8)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .MemRead_EXE       (MemRead_EXE),
    .rd_EXE            (rd_EXE),
    .rs1_ID            (rs1_ID),
    .rs2_ID            (rs2_ID),
    .use_rs1_ID        (use_rs1_ID),
    .use_rs2_ID        (use_rs2_ID),
    .branch_taken_EXE  (branch_taken_EXE),
    .MemRead_MEM       (MemRead_MEM),
    .MemWrite_MEM      (MemWrite_MEM),
    .dmem_ack          (dmem_ack),
    .dmem_req          (dmem_req),
    .PC_Write          (PC_Write),
    .IF_ID_REG_Write   (IF_ID_REG_Write),
    .ID_EXE_REG_Write  (ID_EXE_REG_Write),
    .EXE_MEM_REG_Write (EXE_MEM_REG_Write),
    .MEM_WB_REG_Write  (MEM_WB_REG_Write),
    .IF_ID_flush       (IF_ID_flush),
    .ID_EXE_flush      (ID_EXE_flush),
    .EXE_MEM_flush     (EXE_MEM_flush),
    .MEM_WB_flush      (MEM_WB_flush),
    .mem_err           (mem_err)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] dut_out();
    return {dmem_req, mem_err, PC_Write, IF_ID_REG_Write, ID_EXE_REG_Write,
            EXE_MEM_REG_Write, MEM_WB_REG_Write, IF_ID_flush, ID_EXE_flush,
            EXE_MEM_flush, MEM_WB_flush};
  endfunction

  function automatic bit model_acc();
    return (MemRead_MEM != 4'd0) || (MemWrite_MEM != 4'd0);
  endfunction

  function automatic logic [10:0] model_out();
    bit acc, lu;
    acc = model_acc();
    lu  = (MemRead_EXE != 4'd0) && (rd_EXE != 5'd0) &&
          ((use_rs1_ID && rs1_ID == rd_EXE) || (use_rs2_ID && rs2_ID == rd_EXE));
    if (!reset_n)              return V_RST;
    if (m_err)                 return V_ERR;
    if (acc && !dmem_ack)      return V_STALL;
    if (branch_taken_EXE)      return {acc, 1'b0, 5'b11111, 4'b1100};
    if (lu)                    return {acc, 1'b0, 5'b00111, 4'b0100};
    return {acc, 1'b0, 5'b11111, 4'b0000};
  endfunction

  task automatic model_step();
    bit acc;
    acc = model_acc();
    if (!reset_n) begin
      m_err = 1'b0; m_waiting = 1'b0; m_wait_n = 0;
    end else if (!m_err) begin
      if (acc && !dmem_ack) begin
        if (m_waiting) begin
          m_wait_n++;
          if (TIMEOUT_ON && m_wait_n >= TB_TIMEOUT) m_err = 1'b1;
        end else begin
          m_waiting = 1'b1;
          m_wait_n  = 0;
        end
      end else if (acc && dmem_ack) begin
        m_waiting = 1'b0;
      end
    end
  endtask

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic lit(input string name, input logic [10:0] exp);
    check({name, "_dut"}, dut_out(), exp);
    check({name, "_model"}, model_out(), exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    MemRead_EXE = '0; rd_EXE = '0; rs1_ID = '0; rs2_ID = '0;
    use_rs1_ID = 1'b0; use_rs2_ID = 1'b0; branch_taken_EXE = 1'b0;
    MemRead_MEM = '0; MemWrite_MEM = '0; dmem_ack = 1'b0;
  endtask

  // Per-cycle compare against the model; inputs are stable between negedge and posedge
  initial begin
    forever begin
      @(negedge clk);
      check("cycle", dut_out(), model_out());
      model_step();
    end
  end

  initial begin
    reset_n = 1'b0;
    clear();
    cyc(); #2 lit("reset1", V_RST);
    cyc(); #2 lit("reset2", V_RST);
    cyc(); reset_n = 1'b1; #2 lit("released", V_IDLE);

    cyc(); MemRead_EXE = 4'hF; rd_EXE = 5'd5; rs2_ID = 5'd5; use_rs2_ID = 1'b1;
    #2 lit("load_use", V_LU);
    cyc(); MemRead_EXE = 4'h0; rd_EXE = 5'd0; #2 lit("lu_bubble", V_IDLE);
    cyc(); MemRead_EXE = 4'hF; rd_EXE = 5'd0; rs2_ID = 5'd0; #2 lit("lu_rd0", V_IDLE);
    cyc(); clear(); #2 lit("idle", V_IDLE);

    for (int k = 0; k < 3; k++) begin
      cyc(); MemRead_MEM = 4'b0001; #2 lit("mem_wait", V_STALL);
    end
    cyc(); dmem_ack = 1'b1; #2 lit("mem_ack", V_ACK);
    cyc(); clear(); #2 lit("after_ack", V_IDLE);

    for (int k = 0; k < 2; k++) begin
      cyc(); MemRead_MEM = 4'b0001; branch_taken_EXE = 1'b1; #2 lit("stall_vs_br", V_STALL);
    end
    cyc(); dmem_ack = 1'b1; #2 lit("ack_br", V_ACK_BR);

    cyc(); clear(); MemRead_EXE = 4'h3; rd_EXE = 5'd3; rs1_ID = 5'd3; use_rs1_ID = 1'b1;
    branch_taken_EXE = 1'b1; #2 lit("br_and_lu", V_BR);

    cyc(); clear(); MemWrite_MEM = 4'b0100; dmem_ack = 1'b1; #2 lit("zero_wait", V_ACK);
    cyc(); clear(); #2 lit("zero_wait_next", V_IDLE);

    for (int k = 0; k < 2; k++) begin
      cyc(); MemRead_MEM = 4'b0010; #2 lit("pre_reset_wait", V_STALL);
    end
    cyc(); reset_n = 1'b0; #2 lit("reset_mid_wait", V_RST);
    cyc(); reset_n = 1'b1; clear(); #2 lit("post_reset", V_IDLE);

`ifdef MEM_TIMEOUT_EN
    cyc(); MemRead_MEM = 4'b0001; #2 lit("to_run_stall", V_STALL);
    for (int k = 0; k < TB_TIMEOUT; k++) begin
      cyc(); #2 lit("to_wait", V_STALL);
    end
    cyc(); #2 lit("timeout_err", V_ERR);
    cyc(); dmem_ack = 1'b1; #2 lit("err_sticky", V_ERR);
    cyc(); reset_n = 1'b0; #2 lit("err_reset", V_RST);
    cyc(); reset_n = 1'b1; clear(); #2 lit("err_cleared", V_IDLE);
`else
    for (int k = 0; k < 20; k++) begin
      cyc(); MemRead_MEM = 4'b0001; #2 lit("long_wait", V_STALL);
    end
    cyc(); dmem_ack = 1'b1; #2 lit("long_ack", V_ACK);
    cyc(); clear(); #2 lit("long_after", V_IDLE);
`endif

    for (int i = 0; i < 3000; i++) begin
      cyc();
      reset_n          = ($urandom_range(0, 199) != 0);
      MemRead_EXE      = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'd0;
      rd_EXE           = 5'($urandom_range(0, 3));
      rs1_ID           = 5'($urandom_range(0, 3));
      rs2_ID           = 5'($urandom_range(0, 3));
      use_rs1_ID       = 1'($urandom);
      use_rs2_ID       = 1'($urandom);
      branch_taken_EXE = ($urandom_range(0, 4) == 0);
      dmem_ack         = ($urandom_range(0, 2) == 0);
      if (!(m_waiting && $urandom_range(0, 3) != 0)) begin
        MemRead_MEM  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        MemWrite_MEM = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      end
    end

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It drives the write-enable and flush inputs of the PC and of the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers. It resolves three event sources:
- multi-cycle data-memory accesses, via a req/ack handshake FSM;
- taken branches resolved in EXE;
- load-use hazards detected in ID.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255: max WAIT cycles before memory error (used only with MEM_TIMEOUT_EN).
- CNT_W, default 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports (clk single clock domain; reset_n synchronous, active-low):
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous active-low reset
- MemRead_EXE  in  4  nonzero means the EXE instruction is a load
- rd_EXE  in  5  EXE destination register
- rs1_ID, rs2_ID  in  5 each  ID source registers
- use_rs1_ID, use_rs2_ID  in  1 each  ID instruction reads rs1/rs2
- branch_taken_EXE  in  1  EXE redirect (taken branch/jump)
- MemRead_MEM, MemWrite_MEM  in  4 each  nonzero means the MEM stage accesses memory
- dmem_ack  in  1  memory completes the access this cycle
- dmem_req  out  1  memory access request
- PC_Write, IF_ID_REG_Write, ID_EXE_REG_Write, EXE_MEM_REG_Write, MEM_WB_REG_Write  out  1 each  register advance enables
- IF_ID_flush, ID_EXE_flush, EXE_MEM_flush, MEM_WB_flush  out  1 each  bubble insert
- mem_err  out  1  sticky timeout error (constant 0 without MEM_TIMEOUT_EN)

## Operation
- Signals:
  - mem_acc = |MemRead_MEM or |MemWrite_MEM.
  - load_use = |MemRead_EXE and rd_EXE != 0 and ((use_rs1_ID and rs1_ID == rd_EXE) or (use_rs2_ID and rs2_ID == rd_EXE)).
- FSM states: RUN, WAIT, ERR (ERR exists only with MEM_TIMEOUT_EN). State is registered; all outputs are combinational from state and inputs.
- dmem_req = mem_acc and state ∈ {RUN, WAIT}.
- Memory stall condition: mem_stall = dmem_req and not dmem_ack.
- Outputs are chosen by the first matching priority:
  1. mem_stall: all five write enables = 0, MEM_WB_flush = 1, other flushes = 0. Branch and load-use inputs are ignored and re-evaluated after the stall.
  2. branch_taken_EXE: all enables = 1, IF_ID_flush = 1, ID_EXE_flush = 1.
  3. load_use: PC_Write = 0, IF_ID_REG_Write = 0, ID_EXE_flush = 1, other enables = 1.
  4. Otherwise: all enables = 1, all flushes = 0.
- EXE_MEM_flush is never asserted outside reset and ERR.
- Transitions:
  - RUN→WAIT on mem_stall.
  - WAIT→RUN on dmem_ack.
  - WAIT→ERR when the wait counter reaches TIMEOUT_CYCLES.
  - ERR is held until reset.
- ERR behaviour: dmem_req = 0, all enables = 0, all flushes = 1, mem_err = 1.
- dmem_ack without dmem_req is ignored.

## Timing
- Reset: reset_n low at a rising edge forces state = RUN, counter = 0, mem_err = 0. While reset_n is low, outputs are forced: enables = 0, flushes = 1, dmem_req = 0.
- Reset mid-WAIT abandons the access and drops dmem_req in the same cycle.
- Zero-wait memory (ack in the same cycle as req): 0 stall cycles.
- Ack after k cycles of req: exactly k stall cycles, and the pipeline advances on the ack cycle.
- dmem_req stays high continuously from assertion until the ack cycle inclusive.
- Wait counter:
  - cleared on entry to WAIT;
  - increments each WAIT cycle without ack;
  - saturates, and never wraps.
- Load-use inserts exactly one bubble: on the next cycle rd_EXE is a bubble, so load_use deasserts.
- Branch and load_use in the same cycle: branch wins, and no ID stall occurs.

## Configuration
- MEM_TIMEOUT_EN defined:
  - counter and ERR state are present;
  - reaching TIMEOUT_CYCLES wait cycles asserts sticky mem_err and freezes the pipeline.
- MEM_TIMEOUT_EN undefined:
  - no counter, no ERR state;
  - WAIT lasts indefinitely;
  - mem_err is tied to 0.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN, WAIT, ERR);
  - the default TIMEOUT_CYCLES;
  - the register-index width constant (5).
- Sub-module load_use_detect computes load_use combinationally from the MemRead_EXE/rd_EXE/ID source inputs.
- Top level holds the FSM, the counter and the output priority mux.

## Test plan
- Reset: hold reset_n = 0 for 2 cycles → all enables 0, all flushes 1, dmem_req 0, mem_err 0. Release → all enables 1.
- Load-use: MemRead_EXE = 4'b1111, rd_EXE = 5, rs2_ID = 5, use_rs2_ID = 1 → PC_Write = 0, IF_ID_REG_Write = 0, ID_EXE_flush = 1 for exactly 1 cycle. Repeat with rd_EXE = 0 → no stall.
- Memory wait: MemRead_MEM = 4'b0001, ack after 3 cycles → dmem_req high for 4 cycles, 3 cycles of all enables 0 with MEM_WB_flush = 1, all enables 1 on the ack cycle.
- Stall vs branch: branch_taken_EXE = 1 during the memory wait → no flush until ack. On the ack cycle (branch still high) → IF_ID_flush = ID_EXE_flush = 1.
- Branch plus load-use in the same cycle → IF_ID_flush = ID_EXE_flush = 1, PC_Write = 1.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4: withhold ack → mem_err rises after 4 WAIT cycles, dmem_req drops, and both stay until reset_n = 0.
